// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM states and the
// default bit period used by the parametrised receiver (and later transmitter).
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // 50 MHz clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   rx_pin    - asynchronous serial line (idle high)
//   rx_sync   - line after the 2-flop synchroniser
//   rx_maj    - majority of the last three synchronised samples
//   rx_fall   - synchronised high-to-low transition seen this cycle
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  output logic rx_sync,
  output logic rx_maj,
  output logic rx_fall
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Synchroniser and sample history, reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx_pin};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign rx_sync = sync_q[1];
  assign rx_maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                   (hist_q[1] & hist_q[2]);
  // hist_q[0] holds the previous synchronised value
  assign rx_fall = hist_q[0] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote mid-bit sampling, false-start
// rejection, parity/framing/overrun flags and a one-entry holding register.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   rx_en             - receiver enable; dropping it aborts a frame in flight
//   rx_pin            - asynchronous serial input, idle high, LSB first
//   rx_data/rx_valid  - held word and its valid flag
//   rx_ready          - consumer accept (rx_valid & rx_ready pops the word)
//   parity_err        - parity mismatch of the held word
//   frame_err         - a low stop sample in the held word
//   overrun_err       - 1-cycle pulse when a frame is dropped on a full register
//   busy              - receiver FSM not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned BIT_W = 4;

  logic rx_sync, rx_maj, rx_fall;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx_pin  (rx_pin),
    .rx_sync (rx_sync),
    .rx_maj  (rx_maj),
    .rx_fall (rx_fall)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 strobe_c, commit_c, ferr_c;

  // Frame state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state, bit timing and frame assembly
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit_c = 1'b0;
    strobe_c = (cnt_q == CNT_W'(HALF));
    // frame error including the stop sample being taken right now
    ferr_c   = ferr_q | ~rx_maj;

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      cnt_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_en && rx_fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (strobe_c) begin
          if (rx_maj) begin
            state_d = ST_IDLE;   // false start
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (strobe_c) begin
          // LSB arrives first, so shifting in from the top lands it at bit 0
          shift_d = {rx_maj, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (strobe_c) begin
          perr_d  = rx_maj ^ (^shift_q) ^ (PARITY == PARITY_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe_c) begin
          ferr_d = ferr_c;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            commit_c = 1'b1;
            bit_d    = '0;
            state_d  = rx_maj ? ST_IDLE : ST_BREAK;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en) begin
      state_d  = ST_IDLE;
      commit_c = 1'b0;
    end
  end

  // Holding register and status outputs; accept is applied before commit so a
  // same-cycle accept frees the slot for the new word
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      busy        <= (state_d != ST_IDLE);
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (commit_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_c;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: two receiver configurations (8N1 and 7E2, 16 clk/bit)
// driven with directed and random frames against a frame-level model.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB0 = 8, PM0 = 0, SB0 = 1;
  localparam int DB1 = 7, PM1 = 2, SB1 = 2;

  logic       clk;
  logic       rst;
  logic [1:0] rx_en, rx_pin, rx_ready;
  logic [7:0] rx_data0;
  logic [6:0] rx_data1;
  logic       rx_valid0, rx_valid1, parity_err0, parity_err1;
  logic       frame_err0, frame_err1, overrun_err0, overrun_err1, busy0, busy1;
  logic [1:0] rx_valid, perr_v, ferr_v, ovr_v, busy_v;

  assign rx_valid = {rx_valid1, rx_valid0};
  assign perr_v   = {parity_err1, parity_err0};
  assign ferr_v   = {frame_err1, frame_err0};
  assign ovr_v    = {overrun_err1, overrun_err0};
  assign busy_v   = {busy1, busy0};

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB0), .PARITY(PM0), .STOP_BITS(SB0)) dut0 (
    .clk(clk), .rst(rst), .rx_en(rx_en[0]), .rx_pin(rx_pin[0]),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready[0]),
    .parity_err(parity_err0), .frame_err(frame_err0),
    .overrun_err(overrun_err0), .busy(busy0)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB1), .PARITY(PM1), .STOP_BITS(SB1)) dut1 (
    .clk(clk), .rst(rst), .rx_en(rx_en[1]), .rx_pin(rx_pin[1]),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready[1]),
    .parity_err(parity_err1), .frame_err(frame_err1),
    .overrun_err(overrun_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation state, updated at the falling edge
  int got_q0[$];
  int got_q1[$];
  int rise_cyc[2];
  int vcnt[2];
  int ovr_cnt[2];
  int busy_cnt[2];
  bit vprev[2];

  function automatic int db(input int d);
    return (d == 0) ? DB0 : DB1;
  endfunction

  function automatic int pm(input int d);
    return (d == 0) ? PM0 : PM1;
  endfunction

  function automatic int sb(input int d);
    return (d == 0) ? SB0 : SB1;
  endfunction

  function automatic int rdata(input int d);
    return (d == 0) ? int'(32'(rx_data0)) : int'(32'(rx_data1));
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rise_cyc[d] = 0; vcnt[d] = 0; ovr_cnt[d] = 0; busy_cnt[d] = 0; vprev[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rx_valid[d] && !vprev[d]) rise_cyc[d] = cyc;
      vprev[d] = rx_valid[d];
      if (rx_valid[d]) vcnt[d] = vcnt[d] + 1;
      if (ovr_v[d]) ovr_cnt[d] = ovr_cnt[d] + 1;
      if (busy_v[d]) busy_cnt[d] = busy_cnt[d] + 1;
      if (rx_valid[d] && rx_ready[d]) begin
        if (d == 0) got_q0.push_back(rdata(0) | (int'(perr_v[0]) << 12) | (int'(ferr_v[0]) << 13));
        else        got_q1.push_back(rdata(1) | (int'(perr_v[1]) << 12) | (int'(ferr_v[1]) << 13));
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    rx_pin[d] = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; max_cells > 0 stops after that many bit cells.
  // The line is left at the last driven level.
  task automatic send_frame(input int d, input int data, input bit flip_par,
                            input bit [1:0] stop_low, input int max_cells,
                            output int start_cyc);
    bit q[$];
    int ones;
    bit pb;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < db(d); i++) begin
      q.push_back(bit'((data >> i) & 1));
      ones += (data >> i) & 1;
    end
    if (pm(d) != 0) begin
      pb = bit'(ones % 2);          // even: total count of ones stays even
      if (pm(d) == 1) pb = ~pb;
      if (flip_par) pb = ~pb;
      q.push_back(pb);
    end
    for (int s = 0; s < sb(d); s++) q.push_back(~stop_low[s]);
    tick();
    start_cyc = cyc;
    for (int i = 0; i < q.size(); i++) begin
      if (max_cells > 0 && i >= max_cells) break;
      rx_pin[d] = q[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic expect_word(input int d, input int exp_data, input int exp_perr,
                             input int exp_ferr, input string tag);
    int n;
    int w;
    n = (d == 0) ? got_q0.size() : got_q1.size();
    check({tag, "_present"}, int'(n > 0), 1);
    if (n == 0) return;
    if (d == 0) w = got_q0.pop_front();
    else        w = got_q1.pop_front();
    check({tag, "_data"}, w & 'hFFF, exp_data);
    check({tag, "_perr"}, (w >> 12) & 1, exp_perr);
    check({tag, "_ferr"}, (w >> 13) & 1, exp_ferr);
  endtask

  // Full frame with rx_ready high; the model derives the expected word and flags
  task automatic do_frame(input int d, input int data, input bit flip_par,
                          input bit [1:0] stop_low, input string tag);
    int s, v0, o0, n, lat, smask, exp_ferr, exp_perr;
    v0 = vcnt[d];
    o0 = ovr_cnt[d];
    send_frame(d, data, flip_par, stop_low, 0, s);
    idle(d, CPB);
    smask    = (1 << sb(d)) - 1;
    exp_ferr = ((int'(stop_low) & smask) != 0) ? 1 : 0;
    exp_perr = (pm(d) != 0 && flip_par) ? 1 : 0;
    expect_word(d, data & ((1 << db(d)) - 1), exp_perr, exp_ferr, tag);
    check({tag, "_valid_cycles"}, vcnt[d] - v0, 1);
    check({tag, "_overrun"}, ovr_cnt[d] - o0, 0);
    // last stop cell index; valid follows its mid-cell strobe after sync delay
    n   = db(d) + ((pm(d) != 0) ? 1 : 0) + sb(d);
    lat = rise_cyc[d] - s;
    if (lat < 16 * n + 9 || lat > 16 * n + 15) check({tag, "_latency"}, lat, 16 * n + 12);
    else check({tag, "_latency"}, 1, 1 - int'(lat < 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b0, v0, o0, r;
    rst = 1'b1;
    rx_en = 2'b11;
    rx_pin = 2'b11;
    rx_ready = 2'b11;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", int'(rx_valid[d]), 0);
      check("rst_data", rdata(d), 0);
      check("rst_flags", int'({perr_v[d], ferr_v[d], ovr_v[d]}), 0);
      check("rst_busy", int'(busy_v[d]), 0);
    end
    idle(0, CPB);

    // 8N1 basic frame
    do_frame(0, 'hA5, 1'b0, 2'b00, "t1_a5");

    // even parity, 7 data bits, 2 stop bits
    do_frame(1, 'h03, 1'b1, 2'b00, "t2_par_bad");
    do_frame(1, 'h03, 1'b0, 2'b00, "t2_par_ok");

    // stop bit low followed by a held-low line
    v0 = vcnt[0];
    send_frame(0, 'h00, 1'b0, 2'b01, 0, s);
    repeat (3 * CPB) tick();
    @(negedge clk);
    check("t3_busy_in_break", int'(busy_v[0]), 1);
    check("t3_words_during_low", vcnt[0] - v0, 1);
    idle(0, 2 * CPB);
    @(negedge clk);
    check("t3_busy_after", int'(busy_v[0]), 0);
    check("t3_words_after", vcnt[0] - v0, 1);
    expect_word(0, 'h00, 0, 1, "t3_break");

    // short low glitch on the idle line
    b0 = busy_cnt[0];
    v0 = vcnt[0];
    tick();
    rx_pin[0] = 1'b0;
    repeat (4) tick();
    idle(0, 3 * CPB);
    r = busy_cnt[0] - b0;
    check("t4_busy_pulsed", int'(r > 0 && r < CPB), 1);
    check("t4_no_valid", vcnt[0] - v0, 0);
    check("t4_busy_now", int'(busy_v[0]), 0);

    // overrun with the consumer stalled
    rx_ready[0] = 1'b0;
    o0 = ovr_cnt[0];
    send_frame(0, 'h11, 1'b0, 2'b00, 0, s);
    idle(0, CPB);
    send_frame(0, 'h22, 1'b0, 2'b00, 0, s);
    idle(0, CPB);
    @(negedge clk);
    check("t5_overrun_pulses", ovr_cnt[0] - o0, 1);
    check("t5_held_data", rdata(0), 'h11);
    check("t5_held_valid", int'(rx_valid[0]), 1);
    tick();
    rx_ready[0] = 1'b1;
    tick();
    check("t5_valid_drop", int'(rx_valid[0]), 0);
    expect_word(0, 'h11, 0, 0, "t5_accept");
    check("t5_queue_empty", got_q0.size(), 0);

    // synchronous reset in the middle of the data bits
    rx_ready[0] = 1'b0;
    send_frame(0, 'h33, 1'b0, 2'b00, 0, s);
    idle(0, CPB);
    send_frame(0, 'h5A, 1'b0, 2'b00, 4, s);
    rx_pin[0] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", int'(rx_valid[0]), 0);
    check("t6_rst_data", rdata(0), 0);
    check("t6_rst_flags", int'({perr_v[0], ferr_v[0], ovr_v[0]}), 0);
    check("t6_rst_busy", int'(busy_v[0]), 0);
    rx_ready[0] = 1'b1;
    idle(0, CPB);
    do_frame(0, 'h5A, 1'b0, 2'b00, "t6_after_rst");

    // receiver disabled mid-frame keeps the held word
    rx_ready[0] = 1'b0;
    send_frame(0, 'h44, 1'b0, 2'b00, 0, s);
    idle(0, CPB);
    send_frame(0, 'h5A, 1'b0, 2'b00, 4, s);
    rx_en[0] = 1'b0;
    tick();
    @(negedge clk);
    check("t6_en_busy", int'(busy_v[0]), 0);
    check("t6_en_valid_kept", int'(rx_valid[0]), 1);
    check("t6_en_data_kept", rdata(0), 'h44);
    idle(0, CPB);
    rx_en[0] = 1'b1;
    idle(0, CPB);
    check("t6_en_idle", int'(busy_v[0]), 0);
    rx_ready[0] = 1'b1;
    repeat (2) tick();
    expect_word(0, 'h44, 0, 0, "t6_en_held");
    do_frame(0, 'h5A, 1'b0, 2'b00, "t6_after_en");

    // random frames
    for (int k = 0; k < 6; k++) begin
      do_frame(0, int'($urandom_range(0, 255)), 1'b0, 2'b00, "rnd8n1");
    end
    for (int k = 0; k < 8; k++) begin
      do_frame(1, int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), "rnd7e2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
